// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage
// and the debug/loader master.
package dmem_arb_pkg;

  typedef enum logic {
    S_CPU      = 1'b0,
    S_DBG_RESP = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Width of a counter that must hold 0..max_wait inclusive.
  function automatic int wait_w(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating wait counter for a pending debug request. Clear wins over increment,
// and sat is high once the count has reached MAX.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = wait_w(MAX);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has default priority, debug is served when the CPU is
// idle or forcibly after MAX_WAIT cycles. Optional perf counters under DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_dbg_cnt,
`endif
  output logic              state_dbg
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              dbg_rvalid_q;
  logic              dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_d;
  logic              cpu_act;
  logic              wait_sat;
  logic              gnt;

  assign cpu_act = cpu_memread | cpu_memwrite;

  // Reset forces the no-grant path so the CPU keeps the port while rst is high.
  assign gnt = !rst && (state_q == S_CPU) && dbg_req && (!cpu_act || wait_sat);

  dmem_arb_wait_ctr #(
    .MAX (MAX_WAIT)
  ) u_wait_ctr (
    .clk (clk),
    .rst (rst),
    .inc (dbg_req && !gnt),
    .clr (!dbg_req || gnt),
    .sat (wait_sat)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a grant is always followed by one CPU-owned response cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CPU:      if (gnt) state_d = S_DBG_RESP;
      S_DBG_RESP: state_d = S_CPU;
      default:    state_d = S_CPU;
    endcase
  end

  // Outputs
  always_comb begin
    mem_read  = cpu_memread;
    mem_write = cpu_memwrite;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    dbg_gnt   = 1'b0;
    if (gnt) begin
      mem_read  = !dbg_we;
      mem_write = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      cpu_stall = cpu_act;
      dbg_gnt   = 1'b1;
    end
  end

  assign cpu_rdata = mem_rdata;

  always_comb begin
    dbg_rvalid_d = gnt && !dbg_we;
    dbg_rdata_d  = dbg_rdata_q;
    if (gnt && !dbg_we) begin
      dbg_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign state_dbg  = state_q;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_stall_d;
  logic [31:0] perf_dbg_q;
  logic [31:0] perf_dbg_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, cpu_stall};
    perf_dbg_d   = perf_dbg_q + {31'd0, dbg_gnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_dbg_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_dbg_q   <= perf_dbg_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_dbg_cnt   = perf_dbg_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a shadow-memory reference model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_memread, cpu_memwrite;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr, dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        state_dbg;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_dbg_cnt;
`endif

  int total = 0;
  int bad = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_dbg_cnt(perf_dbg_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / environment memory (256 words, combinational read, posedge write)
  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;

  // Reference model
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];
  bit          m_resp;
  int          m_wait;
  bit          m_rvalid;
  logic [31:0] m_rdata;
  bit          exp_gnt, exp_stall, exp_mr, exp_mw;
  logic [31:0] exp_ma, exp_md;

  task automatic model_eval();
    bit act;
    act = cpu_memread || cpu_memwrite;
    exp_gnt = !rst && !m_resp && dbg_req && (!act || m_wait >= MAX_WAIT);
    exp_stall = exp_gnt && act;
    exp_mr = exp_gnt ? !dbg_we : cpu_memread;
    exp_mw = exp_gnt ? dbg_we : cpu_memwrite;
    exp_ma = exp_gnt ? dbg_addr : cpu_addr;
    exp_md = exp_gnt ? dbg_wdata : cpu_wdata;
  endtask

  task automatic model_commit();
    if (rst) begin
      m_resp = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0;
      exp_q.delete();
    end else begin
      m_rvalid = exp_gnt && !dbg_we;
      if (m_rvalid) begin
        m_rdata = ref_mem[dbg_addr[9:2]];
        exp_q.push_back(m_rdata);
      end
      if (dbg_req && !exp_gnt) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      m_resp = exp_gnt;
    end
    if (exp_mw) ref_mem[exp_ma[9:2]] = exp_md;
  endtask

  task automatic settle();
    model_eval();
    #4;
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // Driver helpers
  task automatic drive_idle();
    cpu_memread = 0; cpu_memwrite = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic drive_cpu_random();
    int r;
    r = $urandom_range(0, 1);
    cpu_memread = (r == 0);
    cpu_memwrite = (r == 1);
    cpu_addr = 32'($urandom_range(0, 255)) << 2;
    cpu_wdata = $urandom;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      settle();
      total++;
      if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0", dbg_gnt); end
      if (i > 0) begin
        total++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0 || state_dbg !== 1'b0) begin
          bad++;
          $display("FAIL rst_regs rvalid=%b rdata=%h state=%b exp 0/0/0", dbg_rvalid, dbg_rdata, state_dbg);
        end
      end
      total++;
      if (mem_addr !== cpu_addr || mem_write !== 1'b0) begin
        bad++; $display("FAIL rst_mux addr=%h we=%b exp cpu path", mem_addr, mem_write);
      end
      tick();
    end
    rst = 0;
    drive_idle();
    settle();
    tick();
  endtask

  task automatic test_cpu_only();
    drive_idle();
    for (int i = 0; i < 40; i++) begin
      drive_cpu_random();
      settle();
      total++;
      if (mem_read !== cpu_memread || mem_write !== cpu_memwrite || mem_addr !== cpu_addr ||
          mem_wdata !== cpu_wdata || cpu_stall !== 1'b0) begin
        bad++;
        $display("FAIL cpu_only cyc=%0d mem r/w/a/d=%b/%b/%h/%h stall=%b exp %b/%b/%h/%h 0", i,
                 mem_read, mem_write, mem_addr, mem_wdata, cpu_stall, cpu_memread, cpu_memwrite,
                 cpu_addr, cpu_wdata);
      end
      if (cpu_memread) begin
        total++;
        if (cpu_rdata !== ref_mem[cpu_addr[9:2]]) begin
          bad++; $display("FAIL cpu_rd cyc=%0d got=%h exp=%h", i, cpu_rdata, ref_mem[cpu_addr[9:2]]);
        end
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_idle_write();
    drive_idle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEADBEEF;
    settle();
    total++;
    if (dbg_gnt !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL idle_wr_gnt gnt=%b we=%b addr=%h data=%h exp 1/1/10/deadbeef", dbg_gnt, mem_write, mem_addr, mem_wdata);
    end
    tick();
    drive_idle();
    cpu_memread = 1; cpu_addr = 32'h10;
    settle();
    total++;
    if (cpu_rdata !== 32'hDEADBEEF || cpu_stall !== 1'b0 || dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL idle_wr_lw rdata=%h stall=%b gnt=%b exp deadbeef/0/0", cpu_rdata, cpu_stall, dbg_gnt);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_idle_read();
    drive_idle();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    settle();
    total++;
    if (dbg_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || dbg_rvalid !== 1'b0) begin
      bad++; $display("FAIL idle_rd_gnt gnt=%b rd=%b wr=%b rvalid=%b exp 1/1/0/0", dbg_gnt, mem_read, mem_write, dbg_rvalid);
    end
    tick();
    drive_idle();
    settle();
    total++;
    if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL idle_rd_resp rvalid=%b rdata=%h exp 1/deadbeef", dbg_rvalid, dbg_rdata);
    end
    tick();
    cpu_memread = 1; cpu_addr = 32'h80;
    settle();
    total++;
    if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL idle_rd_hold rvalid=%b rdata=%h exp 0/deadbeef", dbg_rvalid, dbg_rdata);
    end
    tick();
    drive_idle();
    settle();
    tick();
  endtask

  task automatic test_starvation();
    bit eg;
    drive_idle();
    settle();
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'hA5A5_0001;
    for (int c = 0; c < 20; c++) begin
      drive_cpu_random();
      settle();
      eg = (c == MAX_WAIT) || (c == 2 * MAX_WAIT + 1);
      total++;
      if (dbg_gnt !== eg || cpu_stall !== eg) begin
        bad++; $display("FAIL starve cyc=%0d gnt=%b stall=%b exp=%b", c, dbg_gnt, cpu_stall, eg);
      end
      if (eg) begin
        total++;
        if (mem_addr !== dbg_addr || mem_write !== 1'b1) begin
          bad++; $display("FAIL starve_mux cyc=%0d addr=%h we=%b exp %h/1", c, mem_addr, mem_write, dbg_addr);
        end
      end
      tick();
    end
    drive_idle();
    settle();
    tick();
  endtask

  task automatic test_back_to_back();
    drive_idle();
    settle();
    tick();
    dbg_req = 1; dbg_we = 1;
    for (int c = 0; c < 10; c++) begin
      dbg_addr = 32'h100 + 32'(c * 4);
      dbg_wdata = $urandom;
      settle();
      total++;
      if (dbg_gnt !== (c % 2 == 0) || cpu_stall !== 1'b0 || state_dbg !== (c % 2 == 1)) begin
        bad++;
        $display("FAIL b2b cyc=%0d gnt=%b stall=%b state=%b exp %b/0/%b", c, dbg_gnt, cpu_stall, state_dbg,
                 (c % 2 == 0), (c % 2 == 1));
      end
      tick();
    end
    drive_idle();
    settle();
    tick();
  endtask

  task automatic test_reset_mid();
    bit eg;
    drive_idle();
    settle();
    tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
    settle();
    total++;
    if (dbg_gnt !== 1'b1) begin bad++; $display("FAIL rmid_gnt got=%b exp=1", dbg_gnt); end
    tick();
    rst = 1;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h5555_AAAA;
    drive_cpu_random();
    settle();
    total++;
    if (dbg_rvalid !== 1'b1 || dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL rmid_pend rvalid=%b gnt=%b exp 1/0", dbg_rvalid, dbg_gnt);
    end
    tick();
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      drive_cpu_random();
      settle();
      if (c == 0) begin
        total++;
        if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h0 || state_dbg !== 1'b0) begin
          bad++; $display("FAIL rmid_after rvalid=%b rdata=%h state=%b exp 0/0/0", dbg_rvalid, dbg_rdata, state_dbg);
        end
      end
      eg = (c == MAX_WAIT);
      total++;
      if (dbg_gnt !== eg) begin
        bad++; $display("FAIL rmid_wait cyc=%0d gnt=%b exp=%b", c, dbg_gnt, eg);
      end
      tick();
    end
    drive_idle();
    settle();
    tick();
  endtask

  task automatic test_random();
    bit pend;
    logic [31:0] e;
    int r;
    pend = 0;
    exp_q.delete();
    drive_idle();
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; dbg_req = 1; dbg_we = $urandom_range(0, 1);
        dbg_addr = 32'($urandom_range(0, 255)) << 2; dbg_wdata = $urandom;
      end else if (pend && $urandom_range(0, 19) == 0) begin
        pend = 0; dbg_req = 0;
      end
      r = $urandom_range(0, 4);
      cpu_memread = (r == 1 || r == 3);
      cpu_memwrite = (r == 2 || r == 4);
      cpu_addr = 32'($urandom_range(0, 255)) << 2;
      cpu_wdata = $urandom;
      settle();
      total++;
      if (dbg_gnt !== exp_gnt || cpu_stall !== exp_stall) begin
        bad++; $display("FAIL rnd_arb cyc=%0d gnt=%b stall=%b exp %b/%b", c, dbg_gnt, cpu_stall, exp_gnt, exp_stall);
      end
      total++;
      if (mem_read !== exp_mr || mem_write !== exp_mw || mem_addr !== exp_ma || mem_wdata !== exp_md) begin
        bad++;
        $display("FAIL rnd_mux cyc=%0d r/w/a/d=%b/%b/%h/%h exp %b/%b/%h/%h", c, mem_read, mem_write,
                 mem_addr, mem_wdata, exp_mr, exp_mw, exp_ma, exp_md);
      end
      total++;
      if (dbg_rvalid !== m_rvalid) begin
        bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, dbg_rvalid, m_rvalid);
      end
      total++;
      if (dbg_rvalid) begin
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=none", c, dbg_rdata);
        end else begin
          e = exp_q.pop_front();
          if (dbg_rdata !== e) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, dbg_rdata, e); end
        end
      end else if (dbg_rdata !== m_rdata) begin
        bad++; $display("FAIL rnd_rhold cyc=%0d got=%h exp=%h", c, dbg_rdata, m_rdata);
      end
      if (cpu_memread && !exp_gnt) begin
        total++;
        if (cpu_rdata !== ref_mem[cpu_addr[9:2]]) begin
          bad++; $display("FAIL rnd_cpu_rd cyc=%0d got=%h exp=%h", c, cpu_rdata, ref_mem[cpu_addr[9:2]]);
        end
      end
      if (exp_gnt) pend = 0;
      tick();
      if (!pend) dbg_req = 0;
    end
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_resp = 0; m_wait = 0; m_rvalid = 0; m_rdata = '0;
    rst = 1;
    drive_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_cpu_only();
    test_idle_write();
    test_idle_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
